apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_pkg.sv | 23 ++
 rtl/cmd_fifo.sv | 60 ++++++
 rtl/apb_cmd_master.sv | 162 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared widths, FSM state encodings and the command record for the APB command master.
package apb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 1 + ADDR_W + DATA_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Reads must never leak stale write data onto PWDATA.
  function automatic logic [DATA_W-1:0] wdata_for(input cmd_t c);
    return c.write ? c.wdata : {DATA_W{1'b0}};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: DEPTH entries of {write, addr, wdata}, show-ahead head, push ignored when full.
module cmd_fifo import apb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok_s, pop_ok_s;
  cmd_t             mem_q [DEPTH];

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == {(PTR_W+1){1'b0}});
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; flushing only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB master that drains a command FIFO into IDLE/SETUP/ACCESS transfers and
// reports each completion (or wait-state timeout) as a one-cycle response.
module apb_cmd_master import apb_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              avail_q, avail_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic              fifo_full_s, fifo_empty_s, pop_s, take_next_s;
  cmd_t              head_s, cmd_in_s;

  assign cmd_in_s = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (cmd_valid),
    .din   (cmd_in_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Transfer sequencing; avail_q delays the IDLE launch by one cycle after the FIFO fills.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    avail_d     = ~fifo_empty_s;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = {DATA_W{1'b0}};
    take_next_s = 1'b0;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (avail_q && !fifo_empty_s) begin
          take_next_s = 1'b1;
        end else begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        wait_d    = {WAIT_W{1'b0}};
      end
      ST_ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : PRDATA;
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          take_next_s = ~fifo_empty_s;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th wait state: abort unless the slave answered.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          take_next_s = ~fifo_empty_s;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
    if (take_next_s) begin
      pop_s     = 1'b1;
      state_d   = ST_SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = head_s.write;
      paddr_d   = head_s.addr;
      pwdata_d  = wdata_for(head_s);
    end else begin
      pop_s = 1'b0;
    end
  end

  // FSM, wait counter and registered APB/response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      wait_q      <= {WAIT_W{1'b0}};
      avail_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= {ADDR_W{1'b0}};
      pwdata_q    <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      avail_q     <= avail_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = ~fifo_full_s | PRESET;
  assign busy      = ~PRESET & ((state_q != ST_IDLE) | ~fifo_empty_s);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: vector table plus multi-cycle corner sequences,
// with a scripted APB slave and a response scoreboard.
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int TMO = 16;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [9:0]  cmd_addr = 10'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        cmd_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata, PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PRDATA = 32'hDEAD_BEEF;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;

  apb_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic write; logic [9:0] addr; logic [31:0] wdata; int waits;
    logic [31:0] prdata; logic perr;
    logic [31:0] exp_rdata; logic exp_err; int exp_en;
  } vec_t;
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  typedef struct {
    logic write; logic [9:0] addr; logic [31:0] wdata; int waits;
    logic [31:0] prdata; logic perr;
  } slv_t;

  exp_t exp_q[$];
  slv_t slv_q[$];
  slv_t cur;
  exp_t e;
  vec_t vecs[8];
  int total = 0, bad = 0, rsp_count = 0, en_cnt = 0, acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scripted slave: takes the next behaviour at SETUP, answers after 'waits' ACCESS cycles.
  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      if (slv_q.size() == 0) begin
        chk("slave_unexpected_setup", 32'd1, 32'd0);
      end else begin
        cur = slv_q.pop_front();
        chk("setup_paddr", 32'(PADDR), 32'(cur.addr));
        chk("setup_pwrite", 32'(PWRITE), 32'(cur.write));
        chk("setup_pwdata", PWDATA, cur.write ? cur.wdata : 32'h0);
      end
      acc = 0; PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b0;
    end else if (PSEL && PENABLE) begin
      en_cnt++;
      chk("access_paddr", 32'(PADDR), 32'(cur.addr));
      chk("access_pwdata", PWDATA, cur.write ? cur.wdata : 32'h0);
      if (acc == cur.waits) begin
        PREADY = 1'b1; PRDATA = cur.prdata; PSLVERR = cur.perr;
      end else begin
        PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b1;
      end
      acc++;
    end else begin
      PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b0;
    end
  end

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge PCLK) begin
    if (rsp_valid) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  task automatic push_cmd(input logic w, input logic [9:0] a, input logic [31:0] d, input int waits,
                          input logic [31:0] pr, input logic pe, input logic [31:0] er, input logic ee);
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    chk("push_cmd_ready", 32'(cmd_ready), 32'd1);
    slv_q.push_back('{w, a, d, waits, pr, pe});
    exp_q.push_back('{er, ee});
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget, input string name);
    for (int i = 0; i < budget && rsp_count < n; i++) tick();
    chk(name, 32'(rsp_count >= n), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n, gaps;
    bit started;

    vecs[0] = '{1'b1, 10'h010, 32'hCAFE_0001, 0,   32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1};
    vecs[1] = '{1'b0, 10'h011, 32'h5555_5555, 0,   32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1};
    vecs[2] = '{1'b0, 10'h001, 32'h0000_0000, 3,   32'h0000_00A5, 1'b0, 32'h0000_00A5, 1'b0, 4};
    vecs[3] = '{1'b1, 10'h005, 32'h0000_0001, 0,   32'h0000_9999, 1'b1, 32'h0000_0000, 1'b1, 1};
    vecs[4] = '{1'b0, 10'h3FF, 32'hFFFF_0000, 2,   32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 3};
    vecs[5] = '{1'b0, 10'h155, 32'h0000_0000, 15,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 16};
    vecs[6] = '{1'b0, 10'h2AA, 32'h0000_0000, 255, 32'h0000_7777, 1'b0, 32'h0000_0000, 1'b1, 16};
    vecs[7] = '{1'b1, 10'h000, 32'h0000_1234, 16,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 16};

    // Reset state
    repeat (2) tick();
    @(negedge PCLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    PRESET = 1'b0;
    tick();

    // Table-driven single transfers
    for (int i = 0; i < 8; i++) begin
      en_cnt = 0;
      base = rsp_count;
      push_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].prdata,
               vecs[i].perr, vecs[i].exp_rdata, vecs[i].exp_err);
      wait_rsp(base + 1, 60, "vec_rsp_timeout");
      chk("vec_penable_cycles", 32'(en_cnt), 32'(vecs[i].exp_en));
      chk("vec_busy_after", 32'(busy), 32'd0);
      chk("vec_psel_after", 32'(PSEL), 32'd0);
    end

    // PSEL rises on the 2nd edge after the accepting edge
    base = rsp_count;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h020; cmd_wdata = 32'h42;
    slv_q.push_back('{1'b1, 10'h020, 32'h42, 0, 32'h0, 1'b0});
    exp_q.push_back('{32'h0, 1'b0});
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(negedge PCLK); chk("psel_lat_e0", 32'(PSEL), 32'd0);
    @(negedge PCLK); chk("psel_lat_e1", 32'(PSEL), 32'd0);
    @(negedge PCLK); chk("psel_lat_e2", 32'(PSEL), 32'd1);
    wait_rsp(base + 1, 30, "lat_rsp_timeout");

    // Back-to-back writes keep PSEL high
    push_cmd(1'b1, 10'h000, 32'h12,   0, 32'h0, 1'b0, 32'h0, 1'b0);
    push_cmd(1'b1, 10'h002, 32'h3F,   0, 32'h0, 1'b0, 32'h0, 1'b0);
    push_cmd(1'b1, 10'h004, 32'h1D4C, 0, 32'h0, 1'b0, 32'h0, 1'b0);
    started = 1'b0; n = 0; gaps = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge PCLK);
      if (rsp_valid) n++;
      if (PSEL) started = 1'b1;
      else if (started && n < 3) gaps++;
    end
    chk("b2b_rsp_count", 32'(n), 32'd3);
    chk("b2b_psel_gaps", 32'(gaps), 32'd0);
    tick();

    // Full FIFO: 1 in flight + 4 queued, 6th push dropped
    base = rsp_count;
    for (int k = 0; k < 6; k++) begin
      @(negedge PCLK);
      cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 10'h040 + 10'(k); cmd_wdata = 32'h100 + 32'(k);
      chk("full_cmd_ready", 32'(cmd_ready), (k < 5) ? 32'd1 : 32'd0);
      if (k < 5) begin
        slv_q.push_back('{1'b1, 10'h040 + 10'(k), 32'h100 + 32'(k), (k == 0) ? 10 : 0, 32'h0, 1'b0});
        exp_q.push_back('{32'h0, 1'b0});
      end
      @(posedge PCLK);
    end
    #1 cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    wait_rsp(base + 5, 200, "full_rsp_timeout");
    repeat (10) tick();
    chk("full_rsp_count", 32'(rsp_count), 32'(base + 5));

    // Reset during ACCESS: no response for the lost command
    base = rsp_count;
    push_cmd(1'b0, 10'h0AB, 32'h0, 255, 32'h1111, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20 && !PENABLE; i++) tick();
    chk("rst_reach_access", 32'(PENABLE), 32'd1);
    repeat (2) tick();
    @(negedge PCLK);
    PRESET = 1'b1;
    exp_q.delete();
    @(posedge PCLK); #1;
    chk("midrst_psel", 32'(PSEL), 32'd0);
    chk("midrst_penable", 32'(PENABLE), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (20) tick();
    chk("midrst_no_rsp", 32'(rsp_count), 32'(base));

    // Recovery after reset
    base = rsp_count;
    push_cmd(1'b0, 10'h0CC, 32'h0, 1, 32'h0000_600D, 1'b0, 32'h0000_600D, 1'b0);
    wait_rsp(base + 1, 30, "recover_rsp_timeout");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("slave_queue_empty", 32'(slv_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
